// File: rtl/seq_mag_comparator_pkg.sv
// Shared definitions for the digit-serial magnitude comparator.
// Holds the FSM state encoding and the bit positions inside the result vector.
package cmp_pkg;

   typedef enum logic [1:0] {
      CMP_IDLE    = 2'd0,
      CMP_COMPARE = 2'd1,
      CMP_DONE    = 2'd2
   } cmp_state_e;

   localparam int GT = 2;
   localparam int EQ = 1;
   localparam int LT = 0;

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Handshake and operand/result bundle for seq_mag_comparator.
// signed_mode exists only when SIGNED_CMP_EN is defined.
interface seq_mag_comparator_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SIGNED_CMP_EN
   logic             signed_mode;
`endif
   logic             busy;
   logic             done;
   logic             greater;
   logic             equal;
   logic             less;

   modport master (
      output start, a, b,
`ifdef SIGNED_CMP_EN
      output signed_mode,
`endif
      input  busy, done, greater, equal, less
   );

   modport slave (
      input  start, a, b,
`ifdef SIGNED_CMP_EN
      input  signed_mode,
`endif
      output busy, done, greater, equal, less
   );
endinterface

// File: rtl/seq_mag_comparator_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-wide slice.
// Less-than is implied when neither gt nor eq is set.
module digit_cmp #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             gt,
   output logic             eq
);
   assign gt = (a > b);
   assign eq = (a == b);
endmodule

// File: rtl/seq_mag_comparator.sv
// Digit-serial MSB-first magnitude comparator with start/busy/done handshake.
// Define SIGNED_CMP_EN to add the latched signed_mode input (two's complement compare).
module seq_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   seq_mag_comparator_if.slave cmp
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0]    TOP_IDX  = IW'(NDIG - 1);
   localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

   cmp_state_e       state_r, state_s;
   logic [IW-1:0]    idx_r;
   logic [WIDTH-1:0] a_r, b_r;
   logic             busy_r, done_r;
   logic [2:0]       res_r, res_s;
   logic [DIGIT-1:0] a_sl_s, b_sl_s;
   logic             gt_s, eq_s, flip_s, accept_s, decide_s;
`ifdef SIGNED_CMP_EN
   logic             sgn_r;
`endif

   // Slice selection; signed mode biases the top digit by flipping its sign bit.
   always_comb begin
`ifdef SIGNED_CMP_EN
      flip_s = sgn_r && (idx_r == TOP_IDX);
`else
      flip_s = 1'b0;
`endif
      a_sl_s = a_r[idx_r*DIGIT +: DIGIT] ^ (flip_s ? MSB_MASK : {DIGIT{1'b0}});
      b_sl_s = b_r[idx_r*DIGIT +: DIGIT] ^ (flip_s ? MSB_MASK : {DIGIT{1'b0}});
   end

   digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
      .a  (a_sl_s),
      .b  (b_sl_s),
      .gt (gt_s),
      .eq (eq_s)
   );

   // Next-state, start acceptance and result encoding.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      decide_s = 1'b0;
      res_s    = 3'b000;
      res_s[GT] = gt_s;
      res_s[EQ] = eq_s;
      res_s[LT] = ~gt_s & ~eq_s;
      case (state_r)
         CMP_IDLE: begin
            if (cmp.start) begin
               accept_s = 1'b1;
               state_s  = CMP_COMPARE;
            end else begin
               state_s  = CMP_IDLE;
            end
         end
         CMP_COMPARE: begin
            if (!eq_s || (idx_r == {IW{1'b0}})) begin
               decide_s = 1'b1;
               state_s  = CMP_DONE;
            end else begin
               state_s  = CMP_COMPARE;
            end
         end
         CMP_DONE: begin
            if (cmp.start) begin
               accept_s = 1'b1;
               state_s  = CMP_COMPARE;
            end else begin
               state_s  = CMP_IDLE;
            end
         end
         default: begin
            state_s = CMP_IDLE;
         end
      endcase
   end

   // State, operands, digit index and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= CMP_IDLE;
         idx_r   <= {IW{1'b0}};
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         res_r   <= 3'b000;
`ifdef SIGNED_CMP_EN
         sgn_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == CMP_COMPARE);
         done_r  <= decide_s;
         if (accept_s) begin
            a_r   <= cmp.a;
            b_r   <= cmp.b;
            idx_r <= TOP_IDX;
`ifdef SIGNED_CMP_EN
            sgn_r <= cmp.signed_mode;
`endif
         end else if ((state_r == CMP_COMPARE) && !decide_s) begin
            idx_r <= idx_r - IW'(1);
         end
         if (decide_s) begin
            res_r <= res_s;
         end
      end
   end

   assign cmp.busy    = busy_r;
   assign cmp.done    = done_r;
   assign cmp.greater = res_r[GT];
   assign cmp.equal   = res_r[EQ];
   assign cmp.less    = res_r[LT];
endmodule
